rate_tick_generator: RTL and testbench
======================================

# rate_tick_generator

Loadable 16-bit down counter that produces a one-cycle `tick` every N enabled clocks, in either periodic (auto-reload) or one-shot mode. It is the counting-down counterpart to the free-running up counter. It provides the timebase that paces the HELLO display state machine: the scroll-step strobe for periodic mode, and single delays for one-shot mode.

## Interface
- `WIDTH`, default 16: counter and period width in bits.

- `clock`  in  1: single system clock; all state updates on its rising edge.
- `clearN`  in  1: asynchronous, active-low reset.
- `enable`  in  1: count-enable; a decrement occurs only on edges where `enable`=1 and the block is in RUN.
- `load`  in  1: synchronous load strobe; captures `period`.
- `period`  in  WIDTH: reload value N, unsigned; sampled only when `load`=1.
- `mode`  in  1: 0 selects periodic mode, 1 selects one-shot mode. Sampled every edge; it must be held stable while in RUN.
- `q`  out  WIDTH: current count, registered.
- `tick`  out  1: terminal-count pulse, registered, one cycle wide.
- `busy`  out  1: 1 while the state is RUN.

## Operation
- State register: IDLE, RUN. A reload register `rl[WIDTH-1:0]` is written only by `load`.
- Reset (`clearN`=0, any time, asynchronous) sets:
  - state to IDLE
  - `rl`=0, `q`=0, `tick`=0, `busy`=0
  - An in-progress count is discarded; there is no pending tick after reset is released.
- Priority per edge: reset, then load, then count.
- Load (`load`=1, in any state):
  - Sets `rl`=`period`, `q`=`period`, `tick`=0.
  - If `period`!=0, next state is RUN; if `period`=0, next state is IDLE.
  - Load takes priority over a coincident terminal count. That edge produces no tick and no reload from the old `rl`.
- RUN, `enable`=0: `q` holds, `tick`=0.
- RUN, `enable`=1, `q`>1: `q`=`q`-1, `tick`=0.
- RUN, `enable`=1, `q`=1 (terminal):
  - Periodic mode: `q`=`rl`, `tick`=1, state stays RUN.
  - One-shot mode: `q`=0, `tick`=1, state goes to IDLE.
- IDLE: `q` holds its value, `tick`=0, `enable` is ignored.
- Arithmetic: `q` is never below 0 and never wraps. `q`=0 occurs only in IDLE.
- Result: in periodic mode with period N, there is exactly one tick per N enabled RUN cycles. With N=1, `tick` stays high on every enabled cycle. Disabled cycles stretch the interval and do not reset it.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- Load latency: `q`=`period` and `busy` are visible after the edge that samples `load`=1.
- Periodic mode, N=`period`, `enable` held at 1:
  - `q` sequence after load is N, N-1, …, 1, N, …
  - `tick` is high during each cycle in which `q` shows N again.
  - The first tick occurs N edges after the load edge.
- One-shot mode: `tick` is high for exactly one cycle, concurrent with `q`=0. `busy` falls on the same edge.
- Release of `clearN` is asynchronous to `clock`. The first active edge after release behaves like any IDLE edge.

## Test plan
- Reset, then 10 edges with `enable`=1 and no load. Required: `q`=0, `tick`=0, and `busy`=0 throughout.
- Periodic mode: load `period`=4 with `enable`=1 for 12 edges. Required:
  - `q` = 4, 3, 2, 1, 4, 3, 2, 1, 4, …
  - `tick`=1 exactly at the 4th, 8th and 12th edges after load.
  - `busy`=1 throughout.
- Gating: periodic mode with `period`=3; drop `enable` for 2 cycles while `q`=2. Required: `q` holds at 2 during the gap, and the tick arrives 2 edges later than in the ungated case.
- One-shot mode: load `period`=5 with `enable`=1. Required:
  - `tick` is a single pulse on the 5th edge, with `q`=0 and `busy`=0 at that point.
  - 10 further edges give no tick and `q` stays at 0.
- Load collisions:
  - A load of `period`=7 coincident with `q`=1 gives `q`=7 and `tick`=0.
  - A load of `period`=0 gives IDLE, `busy`=0, and no tick.
- Reset mid-count: assert `clearN`=0 asynchronously between edges while `q`=9. Required: `q`=0, `tick`=0, and `busy`=0 immediately. After release, there are no ticks until the next load.

Source files
------------

// File: rtl/rate_tick_generator.sv
// Loadable down counter emitting a one-cycle tick every N enabled clocks,
// either auto-reloading (periodic) or stopping after one interval (one-shot).
module rate_tick_generator #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             clearN,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] period,
  input  logic             mode,
  output logic [WIDTH-1:0] q,
  output logic             tick,
  output logic             busy
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  state_t           state;
  logic [WIDTH-1:0] rl;

  // Load always wins over counting, so a load landing on the terminal count
  // swallows that tick and never reloads from the stale rl.
  always_ff @(posedge clock or negedge clearN) begin
    if (!clearN) begin
      state <= IDLE;
      rl    <= ZERO;
      q     <= ZERO;
      tick  <= 1'b0;
    end else if (load) begin
      rl    <= period;
      q     <= period;
      tick  <= 1'b0;
      state <= (period != ZERO) ? RUN : IDLE;
    end else if (state == RUN && enable) begin
      if (q > ONE) begin
        q    <= q - ONE;
        tick <= 1'b0;
      end else begin
        // q==0 cannot occur in RUN; treating it as terminal keeps the counter
        // from ever wrapping should it somehow appear.
        tick <= 1'b1;
        if (mode) begin
          q     <= ZERO;
          state <= IDLE;
        end else begin
          q     <= rl;
        end
      end
    end else begin
      tick <= 1'b0;
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_rate_tick_generator.sv
// Self-checking bench for rate_tick_generator: directed scenarios plus random
// load/enable traffic, all compared against a count-of-enabled-edges model.
module tb_rate_tick_generator;

  logic        clock;
  logic        clearN;
  logic        enable;
  logic        load;
  logic [15:0] period;
  logic        mode;
  logic [15:0] q;
  logic        tick;
  logic        busy;

  int errors = 0;
  int checks = 0;

  // Reference model: remembers the loaded N and how many enabled RUN edges
  // have elapsed since the load; outputs follow from plain arithmetic.
  int mN      = 0;
  int mK      = 0;
  bit mActive = 0;
  bit mOneShot = 0;
  bit mInc    = 0;
  bit curMode = 0;

  rate_tick_generator #(.WIDTH(16)) dut (
    .clock  (clock),
    .clearN (clearN),
    .enable (enable),
    .load   (load),
    .period (period),
    .mode   (mode),
    .q      (q),
    .tick   (tick),
    .busy   (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic int modelQ();
    if (!mActive) return 0;
    if (mOneShot) return mN - mK;
    return mN - (mK % mN);
  endfunction

  function automatic bit modelBusy();
    return mActive && (!mOneShot || mK < mN);
  endfunction

  function automatic bit modelTick();
    return mInc && mActive && mK > 0 && (mK % mN) == 0;
  endfunction

  function automatic void modelReset();
    mN = 0; mK = 0; mActive = 0; mOneShot = 0; mInc = 0;
  endfunction

  // Drives one edge's inputs after the falling edge, advances the model on
  // the rising edge, and leaves the caller 1 time unit past that edge.
  task automatic applyStimulus(input bit ld, input int per, input bit en, input bit md);
    bit wasBusy;
    @(negedge clock);
    load   = ld;
    period = 16'(per);
    enable = en;
    mode   = md;
    @(posedge clock);
    wasBusy = modelBusy();
    if (ld) begin
      mN = per; mK = 0; mActive = (per != 0); mOneShot = md; mInc = 0;
    end else if (wasBusy && en) begin
      mK++; mInc = 1;
    end else begin
      mInc = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    clearN = 1'b0; load = 1'b0; enable = 1'b0; period = '0; mode = 1'b0;
    modelReset();
    #3;
    checks++;
    if ({q, tick, busy} !== {16'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_hold: q=%0h tick=%b busy=%b expected q=0 tick=0 busy=0", q, tick, busy);
    end
    @(negedge clock);
    clearN = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(0, 0, 1, 0);
      checks++;
      if ({q, tick, busy} !== {16'(modelQ()), modelTick(), modelBusy()}) begin
        errors++;
        $display("[TB] FAIL idle_after_reset edge %0d: q=%0h tick=%b busy=%b expected q=%0h tick=%b busy=%b",
                 i, q, tick, busy, 16'(modelQ()), modelTick(), modelBusy());
      end
    end
  endtask

  task automatic test_periodic();
    curMode = 0;
    applyStimulus(1, 4, 1, curMode);
    checks++;
    if ({q, tick, busy} !== {16'd4, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL periodic_load: q=%0h tick=%b busy=%b expected q=4 tick=0 busy=1", q, tick, busy);
    end
    for (int i = 1; i <= 12; i++) begin
      applyStimulus(0, 0, 1, curMode);
      checks++;
      if ({q, tick, busy} !== {16'(modelQ()), modelTick(), modelBusy()}) begin
        errors++;
        $display("[TB] FAIL periodic edge %0d: q=%0h tick=%b busy=%b expected q=%0h tick=%b busy=%b",
                 i, q, tick, busy, 16'(modelQ()), modelTick(), modelBusy());
      end
      checks++;
      if (tick !== ((i % 4) == 0)) begin
        errors++;
        $display("[TB] FAIL periodic_tick_slot edge %0d: tick=%b expected %b", i, tick, (i % 4) == 0);
      end
    end
  endtask

  task automatic test_gating();
    bit enSeq [6] = '{1, 0, 0, 1, 1, 1};
    curMode = 0;
    applyStimulus(1, 3, 1, curMode);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, enSeq[i], curMode);
      checks++;
      if ({q, tick, busy} !== {16'(modelQ()), modelTick(), modelBusy()}) begin
        errors++;
        $display("[TB] FAIL gating edge %0d: q=%0h tick=%b busy=%b expected q=%0h tick=%b busy=%b",
                 i + 1, q, tick, busy, 16'(modelQ()), modelTick(), modelBusy());
      end
    end
    // Ungated, the tick would be on edge 3; two dead cycles push it to edge 5.
    checks++;
    if (q !== 16'd2) begin
      errors++;
      $display("[TB] FAIL gating_end_q: q=%0h expected 2", q);
    end
  endtask

  task automatic test_one_shot();
    curMode = 1;
    applyStimulus(1, 5, 1, curMode);
    for (int i = 1; i <= 15; i++) begin
      applyStimulus(0, 0, 1, curMode);
      checks++;
      if ({q, tick, busy} !== {16'(modelQ()), modelTick(), modelBusy()}) begin
        errors++;
        $display("[TB] FAIL one_shot edge %0d: q=%0h tick=%b busy=%b expected q=%0h tick=%b busy=%b",
                 i, q, tick, busy, 16'(modelQ()), modelTick(), modelBusy());
      end
      if (i == 5) begin
        checks++;
        if ({q, tick, busy} !== {16'h0, 1'b1, 1'b0}) begin
          errors++;
          $display("[TB] FAIL one_shot_terminal: q=%0h tick=%b busy=%b expected q=0 tick=1 busy=0", q, tick, busy);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    curMode = 0;
    applyStimulus(1, 2, 1, curMode);
    applyStimulus(0, 0, 1, curMode);
    checks++;
    if (q !== 16'd1) begin
      errors++;
      $display("[TB] FAIL collision_setup: q=%0h expected 1", q);
    end
    applyStimulus(1, 7, 1, curMode);
    checks++;
    if ({q, tick, busy} !== {16'd7, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL load_on_terminal: q=%0h tick=%b busy=%b expected q=7 tick=0 busy=1", q, tick, busy);
    end
    applyStimulus(1, 0, 1, curMode);
    checks++;
    if ({q, tick, busy} !== {16'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL load_zero: q=%0h tick=%b busy=%b expected q=0 tick=0 busy=0", q, tick, busy);
    end
    applyStimulus(1, 65535, 1, curMode);
    applyStimulus(0, 0, 1, curMode);
    checks++;
    if ({q, tick, busy} !== {16'hFFFE, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL max_period: q=%0h tick=%b busy=%b expected q=fffe tick=0 busy=1", q, tick, busy);
    end
    applyStimulus(1, 1, 1, curMode);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(0, 0, 1, curMode);
      checks++;
      if ({q, tick, busy} !== {16'd1, 1'b1, 1'b1}) begin
        errors++;
        $display("[TB] FAIL period_one edge %0d: q=%0h tick=%b busy=%b expected q=1 tick=1 busy=1", i, q, tick, busy);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    curMode = 0;
    applyStimulus(1, 12, 1, curMode);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, curMode);
    checks++;
    if (q !== 16'd9) begin
      errors++;
      $display("[TB] FAIL mid_count_setup: q=%0h expected 9", q);
    end
    #2 clearN = 1'b0;
    modelReset();
    #1;
    checks++;
    if ({q, tick, busy} !== {16'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL async_reset: q=%0h tick=%b busy=%b expected q=0 tick=0 busy=0", q, tick, busy);
    end
    #3 clearN = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(0, 0, 1, curMode);
      checks++;
      if ({q, tick, busy} !== {16'h0, 1'b0, 1'b0}) begin
        errors++;
        $display("[TB] FAIL post_reset_idle edge %0d: q=%0h tick=%b busy=%b expected q=0 tick=0 busy=0",
                 i, q, tick, busy);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 1; i <= 400; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        curMode = 1'($urandom_range(0, 1));
        applyStimulus(1, int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), curMode);
      end else begin
        applyStimulus(0, 0, $urandom_range(0, 3) != 0, curMode);
      end
      checks++;
      if ({q, tick, busy} !== {16'(modelQ()), modelTick(), modelBusy()}) begin
        errors++;
        $display("[TB] FAIL random edge %0d: q=%0h tick=%b busy=%b expected q=%0h tick=%b busy=%b",
                 i, q, tick, busy, 16'(modelQ()), modelTick(), modelBusy());
      end
    end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_gating();
    test_one_shot();
    test_back_to_back();
    test_reset_mid_count();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
